cla_adder_pipe: RTL and testbench
=================================

Name: cla_adder_pipe

Overview:
- Parametrised, pipelined carry-look-ahead adder/subtractor for the datapath.
- Next generation of the fixed 64-bit, 8-bit-group CLA: operand width, group size and pipeline depth are parameters.
- Adds add/subtract mode, signed-overflow and zero flags, and a valid/ready handshake with backpressure on both sides.

Parameters:
- WIDTH, 64: operand width in bits. Must be a multiple of BLOCK.
- BLOCK, 8: bits per CLA group. Carry inside a group is full look-ahead; carry between groups ripples.
- STAGES, 4: number of pipeline register stages. NBLK = WIDTH/BLOCK must be a multiple of STAGES. Each stage handles NBLK/STAGES consecutive groups, LSB groups first.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  block accepts the input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (borrow-in when sub=1)
- sub  in  1  0: A+B+cin; 1: A-B-cin
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  result
- cout  out  1  raw carry out of the MSB (for sub, 1 = no borrow)
- ovf  out  1  two's-complement signed overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (async assert, sync release): every stage valid bit clears. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 from the first cycle after reset releases.
- Effective operands: Be = b XOR {WIDTH{sub}}, c0 = cin XOR sub. Sub mode therefore computes A + ~B + ~cin = A - B - cin mod 2^WIDTH.
- Per group, with P = a^Be and G = a&Be:
  - Internal carries are the full look-ahead expansion C[i+1] = G[i] | P[i]&C[i], flattened.
  - Group sum = P ^ C.
  - Group carry-out feeds the next group.
- Stage k (0..STAGES-1) computes its groups from the carry registered by stage k-1 (stage 0 uses c0).
- Each stage registers:
  - the sum bits done so far;
  - the not-yet-processed a/Be bits (operand skew);
  - the carry into the next stage;
  - the two MSB-column values needed for ovf;
  - a valid bit.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid=1, with no stalls. Throughput is one result per cycle while out_ready=1.
- Flags, registered with the last stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - zero = ~|sum.
- Handshake:
  - A stage advances when its successor is empty or advancing. The last stage advances when out_valid=0 or out_ready=1.
  - in_ready = stage-0 register empty, or stage 0 advancing.
  - Bubbles collapse: an empty stage always accepts.
  - While out_valid=1 and out_ready=0: sum/cout/ovf/zero/out_valid hold unchanged. The pipeline fills until in_ready=0, and no accepted data is dropped or duplicated.
  - in_valid=0 with out_ready=1 drains one result per cycle, in order.
  - Inputs are sampled only on accepting edges. a/b/sub/cin may change freely otherwise.
- Result ordering: strict FIFO, at most STAGES results in flight.
- Reset mid-operation: all in-flight results are discarded and out_valid=0 immediately (async). Nothing reappears after reset release.
- STAGES=1 degenerates to a single registered full-width CLA with latency 1.

Test Plan:
1. Defaults, a=0, b=0, cin=0, sub=0 for one cycle -> exactly 4 cycles later out_valid=1, sum=0, zero=1, cout=0, ovf=0.
2. a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, zero=1, ovf=0. This checks the carry crossing every group and every stage.
3. a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0. Then a=5, b=7, sub=1, cin=0 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
4. Stream 10 random operand pairs back-to-back with out_ready=1 -> 10 consecutive out_valid cycles, results match a golden model in order. Then hold out_ready=0 for 8 cycles -> outputs frozen, in_ready=0 after 4 more accepts, no loss when out_ready returns to 1.
5. With 3 results in flight, pulse rst_n=0 asynchronously between clock edges -> out_valid drops immediately. After release, no stale result appears; in_ready=1.
6. Re-run scenarios 2-4 with WIDTH=32, BLOCK=4, STAGES=2 and WIDTH=16, BLOCK=16, STAGES=1 -> latency equals STAGES and all results match the golden model.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshake.
// Each stage resolves NBLK/STAGES consecutive CLA groups, LSB groups first.
module cla_adder_pipe #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLOCK  = 8,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NBLK  = WIDTH / BLOCK;
    localparam int unsigned GPS   = NBLK / STAGES;
    localparam int unsigned SBITS = GPS * BLOCK;
    localparam int unsigned LAST  = STAGES - 1;

    // Flattened look-ahead carries of one group; c[0] is the group carry-in.
    function automatic logic [BLOCK:0] group_carries(
        input logic [BLOCK-1:0] x,
        input logic [BLOCK-1:0] y,
        input logic             ci
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             term;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < int'(BLOCK); i++) begin
            term = ci;
            for (int j = 0; j <= i; j++) term &= p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) term &= p[k];
                c[i+1] |= term;
            end
        end
        return c;
    endfunction

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  be_q  [STAGES];
    logic [STAGES-1:0] c_q;
    logic              cm_q  [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_be  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_cm;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic [STAGES-1:0] nxt_cm;
    logic [STAGES-1:0] adv;

    // Backpressure chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv       = '0;
        adv[LAST] = ~vld_q[LAST] | out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = ~vld_q[k] | adv[k+1];
        end
    end

    // Stage datapath: take the previous stage's skewed operands and carry,
    // resolve this stage's groups, pass the rest along.
    always_comb begin
        logic             c;
        logic             cm;
        logic [BLOCK:0]   cv;
        int unsigned      base;
        c    = 1'b0;
        cm   = 1'b0;
        cv   = '0;
        base = 0;
        src_a[0]   = a;
        src_be[0]  = b ^ {WIDTH{sub}};
        src_sum[0] = '0;
        src_c      = '0;
        src_cm     = '0;
        src_v      = '0;
        src_c[0]   = cin ^ sub;
        src_v[0]   = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_be[k]  = be_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_c[k]   = c_q[k-1];
            src_cm[k]  = cm_q[k-1];
            src_v[k]   = vld_q[k-1];
        end
        nxt_c  = '0;
        nxt_cm = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_sum[k] = src_sum[k];
            c          = src_c[k];
            cm         = src_cm[k];
            for (int unsigned g = 0; g < GPS; g++) begin
                base = k * SBITS + g * BLOCK;
                cv   = group_carries(src_a[k][base +: BLOCK], src_be[k][base +: BLOCK], c);
                nxt_sum[k][base +: BLOCK] = src_a[k][base +: BLOCK] ^ src_be[k][base +: BLOCK]
                                            ^ cv[BLOCK-1:0];
                c = cv[BLOCK];
                if (base + BLOCK == WIDTH) cm = cv[BLOCK-1];
            end
            nxt_c[k]  = c;
            nxt_cm[k] = cm;
        end
    end

    // Pipeline registers; payload loads only with valid data so idle outputs stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                be_q[k]  <= '0;
                cm_q[k]  <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld_q[k] <= src_v[k];
                    if (src_v[k]) begin
                        sum_q[k] <= nxt_sum[k];
                        a_q[k]   <= src_a[k];
                        be_q[k]  <= src_be[k];
                        c_q[k]   <= nxt_c[k];
                        cm_q[k]  <= nxt_cm[k];
                    end
                end
            end
            if (adv[LAST] && src_v[LAST]) begin
                ovf_q  <= nxt_cm[LAST] ^ nxt_c[LAST];
                zero_q <= ~|nxt_sum[LAST];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: three configurations share one stimulus stream,
// each checked against an arithmetic reference through an in-order scoreboard.
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;

    always #5 clk = ~clk;

    logic        ir0, ov0, co0, of0, z0;
    logic [63:0] s0;
    logic        ir1, ov1, co1, of1, z1;
    logic [31:0] s1;
    logic        ir2, ov2, co2, of2, z2;
    logic [15:0] s2;

    cla_adder_pipe #(.WIDTH(64), .BLOCK(8), .STAGES(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
        .sum(s0), .cout(co0), .ovf(of0), .zero(z0));

    cla_adder_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
        .sum(s1), .cout(co1), .ovf(of1), .zero(z1));

    cla_adder_pipe #(.WIDTH(16), .BLOCK(16), .STAGES(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
        .sum(s2), .cout(co2), .ovf(of2), .zero(z2));

    logic        o_v   [3];
    logic        i_r   [3];
    logic [66:0] o_res [3];
    assign o_v[0] = ov0;
    assign o_v[1] = ov1;
    assign o_v[2] = ov2;
    assign i_r[0] = ir0;
    assign i_r[1] = ir1;
    assign i_r[2] = ir2;
    assign o_res[0] = {of0, z0, co0, s0};
    assign o_res[1] = {of1, z1, co1, 32'h0, s1};
    assign o_res[2] = {of2, z2, co2, 48'h0, s2};

    typedef struct {
        int          inst;
        logic [66:0] res;
        int          stamp;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_stall = -1;

    function automatic int stg(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    function automatic int wid(input int i);
        return (i == 0) ? 64 : (i == 1) ? 32 : 16;
    endfunction

    // Reference result {ovf, zero, cout, sum} from exact integer arithmetic.
    function automatic logic [66:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                          input logic ci, input logic s);
        logic [65:0]        msk, ua, ub, ur;
        logic signed [65:0] sa, sb, sr, smax, smin, sci;
        logic               cy;
        msk  = (66'd1 << w) - 66'd1;
        ua   = {2'b00, av} & msk;
        ub   = {2'b00, bv} & msk;
        sa   = ua;
        sb   = ub;
        if (ua[w-1]) sa = sa - (66'sd1 <<< w);
        if (ub[w-1]) sb = sb - (66'sd1 <<< w);
        smax = (66'sd1 <<< (w - 1)) - 66'sd1;
        smin = -(66'sd1 <<< (w - 1));
        sci  = $signed({65'b0, ci});
        if (!s) begin
            ur = ua + ub + {65'b0, ci};
            cy = ur[w];
            sr = sa + sb + sci;
        end else begin
            ur = ua - ub - {65'b0, ci};
            cy = (ua >= ub + {65'b0, ci});
            sr = sa - sb - sci;
        end
        ur = ur & msk;
        return {(sr > smax) || (sr < smin), ur == 66'd0, cy, ur[63:0]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: check every visible output against the oldest accepted operand set.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (!out_ready) last_stall = cyc;
            for (int i = 0; i < 3; i++) begin
                if (o_v[i]) begin
                    idx = -1;
                    for (int j = 0; j < sbq.size(); j++)
                        if (idx < 0 && sbq[j].inst == i) idx = j;
                    if (idx < 0) begin
                        chk($sformatf("stale_out%0d", i), 128'(o_v[i]), 128'(0));
                    end else begin
                        chk($sformatf("result%0d", i), 128'(o_res[i]), 128'(sbq[idx].res));
                        if (last_stall < sbq[idx].stamp)
                            chk($sformatf("latency%0d", i), 128'(cyc - sbq[idx].stamp), 128'(stg(i)));
                        if (out_ready) sbq.delete(idx);
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (in_valid && i_r[i]) begin
                    e.inst  = i;
                    e.res   = model(wid(i), a, b, cin, sub);
                    e.stamp = cyc;
                    sbq.push_back(e);
                end
            end
        end
    end

    function automatic logic [63:0] rnd64();
        case ($urandom % 8)
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_8000_8000_8000;
            3:       return 64'h7FFF_7FFF_7FFF_7FFF;
            4:       return {32'h0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic drive_rand(input logic v);
        @(posedge clk);
        #1;
        in_valid = v;
        a        = rnd64();
        b        = rnd64();
        cin      = 1'($urandom % 2);
        sub      = 1'($urandom % 2);
    endtask

    // One transaction into an idle pipe, then the 4-stage instance's latency and result.
    task automatic directed(input string name, input logic [63:0] av, input logic [63:0] bv,
                            input logic c, input logic s, input logic [66:0] exp);
        int lat;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = av; b = bv; cin = c; sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (o_v[0]) break;
        end
        chk({name, "_valid"}, 128'(o_v[0]), 128'(1));
        chk({name, "_lat"}, 128'(lat), 128'(4));
        chk({name, "_res"}, 128'(o_res[0]), 128'(exp));
    endtask

    initial begin
        int acc [3];
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        chk("pin_allones_plus1", 128'(model(64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0)),
            128'({1'b0, 1'b1, 1'b1, 64'h0}));
        chk("pin_min_minus1", 128'(model(32, 64'h8000_0000, 64'h1, 1'b0, 1'b1)),
            128'({1'b1, 1'b0, 1'b1, 64'h7FFF_FFFF}));
        chk("pin_equal_sub", 128'(model(16, 64'h5, 64'h5, 1'b0, 1'b1)),
            128'({1'b0, 1'b1, 1'b1, 64'h0}));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 128'({ov0, o_res[0]}), 128'(0));
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 128'({ir0, ir1, ir2}), 128'(3'b111));

        directed("zero_add", 64'h0, 64'h0, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 64'h0});
        directed("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, {1'b0, 1'b1, 1'b1, 64'h0});
        directed("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                 {1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000});
        directed("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1,
                 {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});

        for (int i = 0; i < 10; i++) drive_rand(1'b1);
        drive_rand(1'b0);
        repeat (8) @(negedge clk);
        chk("stream_drained", 128'(sbq.size()), 128'(0));

        // Backpressure into an empty pipe: exactly STAGES accepts before in_ready drops.
        acc = '{0, 0, 0};
        for (int k = 0; k < 8; k++) begin
            drive_rand(1'b1);
            if (k == 0) out_ready = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (i_r[i]) acc[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_accepts%0d", i), 128'(acc[i]), 128'(stg(i)));
            chk($sformatf("bp_ready%0d", i), 128'(i_r[i]), 128'(0));
        end
        drive_rand(1'b0);
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_drained", 128'(sbq.size()), 128'(0));

        for (int k = 0; k < 400; k++) begin
            drive_rand(1'($urandom % 4 != 0));
            out_ready = 1'($urandom % 3 != 0);
        end
        drive_rand(1'b0);
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("random_drained", 128'(sbq.size()), 128'(0));

        // Asynchronous reset with results in flight.
        for (int k = 0; k < 4; k++) drive_rand(1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 128'({ov0, ov1, ov2}), 128'(3'b111));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_drop", 128'({ov0, ov1, ov2}), 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_idle", 128'({ov0, ov1, ov2}), 128'(0));
        chk("post_reset_ready", 128'({ir0, ir1, ir2}), 128'(3'b111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
